// File: rtl/light_cmd_parser.sv
// ASCII light-puzzle line parser: emits one packed command per line with a one-deep lookahead so the final command carries last.
// Optional build macro LIGHT_CMD_PARSER_ERR_CHECK_EN drops malformed lines and counts them on err_count.
module light_cmd_parser #(
   parameter int INSTRUCTION_WIDTH = 50,
   parameter int POSITION_BITS     = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         byte_valid,
   output logic                         byte_ready,
   input  logic [7:0]                   byte_data,
   input  logic                         byte_last,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [INSTRUCTION_WIDTH-1:0] instr_data,
   output logic                         instr_last,
   output logic                         done
`ifdef LIGHT_CMD_PARSER_ERR_CHECK_EN
   ,
   output logic [15:0]                  err_count
`endif
);

   localparam int CMD_W = 2 + 4 * POSITION_BITS;
   localparam logic [1:0] OP_OFF = 2'b00;
   localparam logic [1:0] OP_TOG = 2'b01;
   localparam logic [1:0] OP_ON  = 2'b11;
   localparam logic [7:0] CH_NL  = 8'h0A;
   localparam logic [7:0] CH_O   = 8'h6F;
   localparam logic [7:0] CH_N   = 8'h6E;
   localparam logic [7:0] CH_F   = 8'h66;

   typedef enum logic [1:0] {S_PARSE, S_FLUSH, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [2:0]               pos_q, pos_d;
   logic [2:0]               fld_q, fld_d;
   logic                     in_num_q, in_num_d;
   logic                     tog_q, tog_d;
   logic                     on_q, on_d;
   logic                     off_q, off_d;
   logic [POSITION_BITS-1:0] fields_q [4];
   logic [POSITION_BITS-1:0] fields_d [4];
   logic [POSITION_BITS-1:0] f_cur [4];
   logic                     held_valid_q, held_valid_d;
   logic                     held_last_q, held_last_d;
   logic [CMD_W-1:0]         held_data_q, held_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [CMD_W-1:0]         out_data_q, out_data_d;

   logic             byte_acc;
   logic             is_digit;
   logic             is_nl;
   logic [3:0]       digit;
   logic [2:0]       fld_inc;
   logic [2:0]       n_fields;
   logic             line_end;
   logic             cmd_ok;
   logic             cmp;
   logic [1:0]       op;
   logic [CMD_W-1:0] cmd;
   logic             out_free;

   assign byte_acc = byte_valid && byte_ready;
   assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
   assign is_nl    = (byte_data == CH_NL);
   assign digit    = byte_data[3:0];
   assign fld_inc  = (fld_q == 3'd4) ? 3'd4 : fld_q + 3'd1;
   // A newline closes the digit run in progress, so it counts as one more field.
   assign n_fields = is_nl ? (in_num_q ? fld_inc : fld_q) : fld_inc;
   assign line_end = byte_acc && (is_nl ? (n_fields != 3'd0) : (byte_last && is_digit));
   assign op       = tog_q ? OP_TOG : (on_q ? OP_ON : OP_OFF);

`ifdef LIGHT_CMD_PARSER_ERR_CHECK_EN
   logic [15:0] err_q, err_d;
   assign cmd_ok    = (n_fields == 3'd4) && (tog_q || on_q || off_q);
   assign err_d     = (line_end && !cmd_ok && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   assign err_count = err_q;
`else
   assign cmd_ok = 1'b1;
`endif

   assign cmp = line_end && cmd_ok;

   always_comb begin : field_accumulate
      for (int i = 0; i < 4; i++) begin
         if (is_digit && fld_q == 3'(i))
            f_cur[i] = fields_q[i] * POSITION_BITS'(10) + POSITION_BITS'(digit);
         else
            f_cur[i] = fields_q[i];
      end
   end

   assign cmd = {op, f_cur[0], f_cur[1], f_cur[2], f_cur[3]};

   always_comb begin : parse_next
      pos_d    = pos_q;
      fld_d    = fld_q;
      in_num_d = in_num_q;
      tog_d    = tog_q;
      on_d     = on_q;
      off_d    = off_q;
      for (int i = 0; i < 4; i++) fields_d[i] = fields_q[i];
      if (byte_acc) begin
         if (is_nl) begin
            pos_d    = 3'd0;
            fld_d    = 3'd0;
            in_num_d = 1'b0;
            tog_d    = 1'b0;
            on_d     = 1'b0;
            off_d    = 1'b0;
            for (int i = 0; i < 4; i++) fields_d[i] = '0;
         end else begin
            pos_d = (pos_q == 3'd7) ? pos_q : pos_q + 3'd1;
            if (pos_q == 3'd1 && byte_data == CH_O) tog_d = 1'b1;
            if (pos_q == 3'd6) begin
               on_d  = (byte_data == CH_N);
               off_d = (byte_data == CH_F);
            end
            in_num_d = is_digit;
            if (!is_digit && in_num_q) fld_d = fld_inc;
            for (int i = 0; i < 4; i++) fields_d[i] = f_cur[i];
         end
      end
   end

   assign out_free = !out_valid_q || instr_ready;

   // HELD only reaches the output once it is known whether it is the final command.
   always_comb begin : queue_next
      held_valid_d = held_valid_q;
      held_last_d  = held_last_q;
      held_data_d  = held_data_q;
      out_valid_d  = out_valid_q && !instr_ready;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      case (state_q)
         S_PARSE: begin
            if (byte_acc && byte_last) begin
               if (held_valid_q) begin
                  out_valid_d = 1'b1;
                  out_data_d  = held_data_q;
                  out_last_d  = !cmp;
                  if (cmp) begin
                     held_data_d = cmd;
                     held_last_d = 1'b1;
                  end else begin
                     held_valid_d = 1'b0;
                  end
               end else if (cmp) begin
                  if (out_free) begin
                     out_valid_d = 1'b1;
                     out_data_d  = cmd;
                     out_last_d  = 1'b1;
                  end else begin
                     held_valid_d = 1'b1;
                     held_data_d  = cmd;
                     held_last_d  = 1'b1;
                  end
               end
            end else if (cmp) begin
               if (held_valid_q) begin
                  out_valid_d = 1'b1;
                  out_data_d  = held_data_q;
                  out_last_d  = 1'b0;
               end
               held_valid_d = 1'b1;
               held_data_d  = cmd;
               held_last_d  = 1'b0;
            end
         end
         S_FLUSH: begin
            if (out_free && held_valid_q) begin
               out_valid_d  = 1'b1;
               out_data_d   = held_data_q;
               out_last_d   = held_last_q;
               held_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         S_PARSE: if (byte_acc && byte_last)
                     state_d = (out_valid_d || held_valid_d) ? S_FLUSH : S_DONE;
         S_FLUSH: if (!out_valid_d && !held_valid_d) state_d = S_DONE;
         default: state_d = S_DONE;
      endcase
   end

   always_comb begin : fsm_out
      byte_ready = !reset && (state_q == S_PARSE) && !(out_valid_q && held_valid_q);
      done       = (state_q == S_DONE);
   end

   always_comb begin : out_widen
      instr_data              = '0;
      instr_data[CMD_W-1:0]   = out_data_q;
   end
   assign instr_valid = out_valid_q;
   assign instr_last  = out_last_q;

   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state_q      <= S_PARSE;
         pos_q        <= '0;
         fld_q        <= '0;
         in_num_q     <= 1'b0;
         tog_q        <= 1'b0;
         on_q         <= 1'b0;
         off_q        <= 1'b0;
         fields_q     <= '{default: '0};
         held_valid_q <= 1'b0;
         held_last_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
`ifdef LIGHT_CMD_PARSER_ERR_CHECK_EN
         err_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         fld_q        <= fld_d;
         in_num_q     <= in_num_d;
         tog_q        <= tog_d;
         on_q         <= on_d;
         off_q        <= off_d;
         fields_q     <= fields_d;
         held_valid_q <= held_valid_d;
         held_last_q  <= held_last_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
`ifdef LIGHT_CMD_PARSER_ERR_CHECK_EN
         err_q        <= err_d;
`endif
      end
   end

   always_ff @(posedge clk) begin : held_data_reg
      held_data_q <= held_data_d;
   end

endmodule
